// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage in front of the 64-bit ALU.
// Requests are buffered in a small FIFO and sent to the ALU one at a time.
// Operands stay stable until the ALU reports done or the wait times out.
// The result, or an error response, is then held in a valid/ready response register.
// Optional feature: define ALU_DISPATCH_NOP_SKIP_EN to answer op==0 locally
// with a zero-flag response, without issuing it to the ALU.
module alu_dispatch #(
    parameter int DATA_W  = 64,
    parameter int OP_W    = 8,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [5:0]        alu_flags,
    input  logic              alu_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic [5:0]        rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W  = 2 * DATA_W + OP_W + TAG_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state_reg, state_next;

    // Request FIFO storage and bookkeeping
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DEPTH-1:0]  wr_sel;
    logic              push, pop, fifo_empty;

    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;
    logic [TAG_W-1:0]  head_tag;
    logic              head_is_nop;

    // WAIT-state cycle counter; wcnt_inc is the count including the current cycle
    logic [WCNT_W-1:0] wcnt_reg, wcnt_inc;

    // Operation currently presented to the ALU
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic              alu_valid_reg;
    logic [TAG_W-1:0]  tag_reg;

    // Response register
    logic              rsp_valid_reg, rsp_err_reg;
    logic [DATA_W-1:0] rsp_res_reg;
    logic [5:0]        rsp_flags_reg;
    logic [TAG_W-1:0]  rsp_tag_reg;

    // Control strobes from the FSM
    logic load_alu, wcnt_clr, wcnt_step;
    logic rsp_set_done, rsp_set_err, rsp_set_nop, rsp_clr;

    assign fifo_empty = (count_reg == '0);
    assign req_ready  = (count_reg < CNT_W'(DEPTH));
    assign push       = req_valid && req_ready;
    assign {head_a, head_b, head_op, head_tag} = mem[rd_ptr_reg];
    assign wcnt_inc   = wcnt_reg + WCNT_W'(1);

`ifdef ALU_DISPATCH_NOP_SKIP_EN
    assign head_is_nop = (head_op == '0);
`else
    assign head_is_nop = 1'b0;
`endif

    // One-hot write select, one bit per FIFO slot
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // FIFO storage write; no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= {req_a, req_b, req_op, req_tag};
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Next-state and control strobes for the issue sequencer
    always_comb begin
        state_next   = state_reg;
        pop          = 1'b0;
        load_alu     = 1'b0;
        wcnt_clr     = 1'b0;
        wcnt_step    = 1'b0;
        rsp_set_done = 1'b0;
        rsp_set_err  = 1'b0;
        rsp_set_nop  = 1'b0;
        rsp_clr      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    load_alu = 1'b1;
                    if (head_is_nop) begin
                        rsp_set_nop = 1'b1;
                        state_next  = RESP;
                    end else begin
                        state_next  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wcnt_clr   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                wcnt_step = 1'b1;
                // A done seen in the first WAIT cycle belongs to the previous op
                if (alu_done && (wcnt_inc >= WCNT_W'(2))) begin
                    rsp_set_done = 1'b1;
                    state_next   = RESP;
                end else if (wcnt_inc >= WCNT_W'(TIMEOUT)) begin
                    rsp_set_err  = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clr = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        load_alu = 1'b1;
                        if (head_is_nop) begin
                            rsp_set_nop = 1'b1;
                            state_next  = RESP;
                        end else begin
                            state_next  = ISSUE;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, wait counter and ALU valid (high through ISSUE and WAIT)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            alu_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            alu_valid_reg <= (state_next == ISSUE) || (state_next == WAIT);
            if (wcnt_clr)       wcnt_reg <= '0;
            else if (wcnt_step) wcnt_reg <= wcnt_inc;
        end
    end

    // Operand and tag capture on pop; held stable until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            tag_reg    <= '0;
        end else if (load_alu) begin
            alu_a_reg  <= head_a;
            alu_b_reg  <= head_b;
            alu_op_reg <= head_op;
            tag_reg    <= head_tag;
        end
    end

    // Response register: load on completion, timeout or NOP; release on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_res_reg   <= '0;
            rsp_flags_reg <= '0;
            rsp_tag_reg   <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (rsp_set_done) begin
            rsp_valid_reg <= 1'b1;
            rsp_res_reg   <= alu_res;
            rsp_flags_reg <= alu_flags;
            rsp_tag_reg   <= tag_reg;
            rsp_err_reg   <= 1'b0;
        end else if (rsp_set_err) begin
            rsp_valid_reg <= 1'b1;
            rsp_res_reg   <= '0;
            rsp_flags_reg <= '0;
            rsp_tag_reg   <= tag_reg;
            rsp_err_reg   <= 1'b1;
        end else if (rsp_set_nop) begin
            rsp_valid_reg <= 1'b1;
            rsp_res_reg   <= '0;
            rsp_flags_reg <= 6'b100000;
            rsp_tag_reg   <= head_tag;
            rsp_err_reg   <= 1'b0;
        end else if (rsp_clr) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign alu_valid = alu_valid_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_res   = rsp_res_reg;
    assign rsp_flags = rsp_flags_reg;
    assign rsp_tag   = rsp_tag_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Testbench for alu_dispatch: directed steps plus randomized traffic, with an
// ALU model (configurable done delay, optional stale done) and an in-order
// scoreboard of expected responses.
module tb_alu_dispatch;
    localparam int DATA_W  = 64;
    localparam int OP_W    = 8;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [DATA_W-1:0] req_a, req_b;
    logic [OP_W-1:0]   req_op;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic [OP_W-1:0]   alu_op;
    logic              alu_valid, alu_done;
    logic [5:0]        alu_flags;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_res;
    logic [5:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  flags;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    typedef struct {
        int d;
        bit stale;
    } job_t;

    rsp_t exp_q[$];
    job_t job_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_rsp  = 0;

    always #5 clk = ~clk;

    alu_dispatch #(
        .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
        .alu_res(alu_res), .alu_flags(alu_flags), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    task automatic check(input string name, input logic [135:0] obs, input logic [135:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // ALU function: {flags, res}, flags = {zero,gt,lt,eq,overflow,carry}
    function automatic logic [69:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [7:0] op);
        logic [64:0] wide;
        logic [63:0] r;
        logic [5:0]  f;
        f    = '0;
        r    = '0;
        wide = '0;
        case (op)
            8'h01: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[63:0];
                f[0] = wide[64];
                f[1] = (a[63] == b[63]) && (r[63] != a[63]);
            end
            8'h02: r = a ^ b;
            8'h03: begin
                r    = a - b;
                f[0] = (a < b);
                f[1] = (a[63] != b[63]) && (r[63] != a[63]);
            end
            8'h04: r = a & b;
            default: r = a | b;
        endcase
        f[5] = (r == 64'd0);
        return {f, r};
    endfunction

    function automatic bit is_nop(input logic [7:0] op);
`ifdef ALU_DISPATCH_NOP_SKIP_EN
        return (op == 8'h00);
`else
        return (op == 8'h00) && 1'b0;
`endif
    endfunction

    // Reference: an op completes at WAIT cycle max(2, done delay) unless that exceeds TIMEOUT
    function automatic rsp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [7:0] op, input logic [3:0] tag, input int d);
        rsp_t        e;
        logic [69:0] fr;
        int          need;
        e.tag = tag;
        e.err = 1'b0;
        if (is_nop(op)) begin
            e.res   = '0;
            e.flags = 6'b100000;
        end else begin
            need = (d > 2) ? d : 2;
            if (need > TIMEOUT) begin
                e.res   = '0;
                e.flags = '0;
                e.err   = 1'b1;
            end else begin
                fr      = alu_fn(a, b, op);
                e.res   = fr[63:0];
                e.flags = fr[69:64];
            end
        end
        return e;
    endfunction

    // ALU model: done at cycle d after valid rises, optional stale done in the first WAIT cycle
    int           vcnt       = 0;
    int           cur_d      = NEVER;
    bit           cur_stale  = 1'b0;
    logic [63:0]  last_res   = '0;
    logic [5:0]   last_flags = '0;
    logic [135:0] cap_ops    = '0;
    logic [69:0]  fn_out;
    logic         live_done;
    job_t         cur_job;

    assign fn_out    = alu_fn(alu_a, alu_b, alu_op);
    assign live_done = alu_valid && (vcnt != 0) && (vcnt >= cur_d);
    assign alu_done  = live_done || (alu_valid && (vcnt == 1) && cur_stale);
    assign alu_res   = live_done ? fn_out[63:0]  : last_res;
    assign alu_flags = live_done ? fn_out[69:64] : last_flags;

    always @(posedge clk) begin
        if (live_done) begin
            last_res   <= fn_out[63:0];
            last_flags <= fn_out[69:64];
        end
        if (rst || !alu_valid) begin
            vcnt <= 0;
        end else begin
            if (vcnt == 0) begin
                check("issue_has_job", 136'(job_q.size() != 0), 136'(1));
                if (job_q.size() != 0) begin
                    cur_job = job_q.pop_front();
                    cur_d     <= cur_job.d;
                    cur_stale <= cur_job.stale;
                end else begin
                    cur_d     <= NEVER;
                    cur_stale <= 1'b0;
                end
                cap_ops <= {alu_a, alu_b, alu_op};
            end
            vcnt <= vcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && alu_valid && vcnt != 0)
            check("alu_operands_stable", {alu_a, alu_b, alu_op}, cap_ops);
    end

    // Response monitor: hold stability while stalled, in-order compare on handshake
    rsp_t mon_held, mon_e;
    bit   hold_chk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else if (rsp_valid) begin
            if (hold_chk) begin
                check("hold_res",   rsp_res,   mon_held.res);
                check("hold_flags", rsp_flags, mon_held.flags);
                check("hold_tag",   rsp_tag,   mon_held.tag);
                check("hold_err",   rsp_err,   mon_held.err);
            end
            if (rsp_ready) begin
                n_rsp++;
                hold_chk = 1'b0;
                check("rsp_expected", 136'(exp_q.size() != 0), 136'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_res",   rsp_res,   mon_e.res);
                    check("rsp_flags", rsp_flags, mon_e.flags);
                    check("rsp_tag",   rsp_tag,   mon_e.tag);
                    check("rsp_err",   rsp_err,   mon_e.err);
                end
            end else begin
                mon_held.res   = rsp_res;
                mon_held.flags = rsp_flags;
                mon_held.tag   = rsp_tag;
                mon_held.err   = rsp_err;
                hold_chk       = 1'b1;
            end
        end else begin
            hold_chk = 1'b0;
        end
    end

    // Drive one request; called and returning at posedge+1, accepted at the posedge it waits for
    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [7:0] op,
                        input logic [3:0] tag, input int d, input bit stale);
        bit   ok = 1'b0;
        job_t j;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(a, b, op, tag, d));
                if (!is_nop(op)) begin
                    j.d = d;
                    j.stale = stale;
                    job_q.push_back(j);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) check("push_accept", 136'(ok), 136'(1));
    endtask

    task automatic wait_rsp(input int target, input int limit);
        for (int i = 0; i < limit && n_rsp < target; i++) begin
            @(posedge clk); #1;
        end
        check("rsp_count", 136'(n_rsp), 136'(target));
    endtask

    initial begin
        #2_000_000;
        n_miss++;
        $display("FAIL watchdog: simulation did not finish, %0d responses seen", n_rsp);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        logic [63:0] ra, rb;
        logic [7:0]  rop;
        int          rd;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 136'(req_ready), 136'(1));
        check("rst_alu_valid", 136'(alu_valid), 136'(0));
        check("rst_alu_a",     alu_a,     136'(0));
        check("rst_alu_b",     alu_b,     136'(0));
        check("rst_alu_op",    alu_op,    136'(0));
        check("rst_rsp_valid", 136'(rsp_valid), 136'(0));
        check("rst_rsp_res",   rsp_res,   136'(0));
        check("rst_rsp_flags", rsp_flags, 136'(0));
        check("rst_rsp_tag",   rsp_tag,   136'(0));
        check("rst_rsp_err",   136'(rsp_err), 136'(0));
        rst = 1'b0;

        // ADD with done two cycles after valid: response 5 cycles after push
        rsp_ready = 1'b1;
        base = n_rsp;
        push(64'd5, 64'd7, 8'h01, 4'd3, 2, 1'b1);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("add_latency", 136'(lat), 136'(5));
        check("add_res",   rsp_res,   136'(12));
        check("add_flags", rsp_flags, 136'(0));
        check("add_tag",   rsp_tag,   136'(3));
        wait_rsp(base + 1, 20);

        // Backpressure: three ops with rsp_ready low, then a fourth push waits for space
        rsp_ready = 1'b0;
        base = n_rsp;
        push(64'd5,    64'd7,    8'h01, 4'd4, 2, 1'b0);
        push(64'hF0,   64'h0F,   8'h02, 4'd5, 2, 1'b1);
        push(64'd1,    64'd2,    8'h03, 4'd6, 2, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("bp_req_ready_full", 136'(req_ready), 136'(0));
        check("bp_rsp_valid",      136'(rsp_valid), 136'(1));
        check("bp_first_res",      rsp_res,   136'(12));
        fork
            push(64'h33, 64'h44, 8'h04, 4'd7, 3, 1'b0);
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                end
                rsp_ready = 1'b1;
            end
        join
        wait_rsp(base + 4, 100);

        // Timeout: first op never completes, second op issues normally afterwards
        base = n_rsp;
        push(64'd9, 64'd9, 8'h01, 4'd8, NEVER, 1'b1);
        push(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 4'd2, 3, 1'b1);
        lat = 2;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("timeout_latency", 136'(lat), 136'(3 + TIMEOUT));
        check("timeout_err",     136'(rsp_err), 136'(1));
        check("timeout_res",     rsp_res, 136'(0));
        wait_rsp(base + 2, 60);

        // Reset in WAIT abandons the op and empties the FIFO
        base = n_rsp;
        push(64'd1, 64'd1, 8'h01, 4'd10, NEVER, 1'b0);
        push(64'd2, 64'd2, 8'h01, 4'd11, 2, 1'b0);
        for (int i = 0; i < 20 && !alu_valid; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_alu_valid", 136'(alu_valid), 136'(0));
        check("rstmid_rsp_valid", 136'(rsp_valid), 136'(0));
        check("rstmid_req_ready", 136'(req_ready), 136'(1));
        exp_q.delete();
        job_q.delete();
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("rstmid_no_rsp", 136'(n_rsp), 136'(base));

`ifdef ALU_DISPATCH_NOP_SKIP_EN
        // NOP answered locally without raising alu_valid
        begin
            bit saw_valid = 1'b0;
            base = n_rsp;
            push(64'd0, 64'd0, 8'h00, 4'd9, 2, 1'b0);
            lat = 1;
            while (!rsp_valid && lat < 20) begin
                if (alu_valid) saw_valid = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
            check("nop_alu_valid", 136'(saw_valid), 136'(0));
            check("nop_flags", rsp_flags, 136'(6'b100000));
            check("nop_tag",   rsp_tag,   136'(9));
            wait_rsp(base + 1, 20);
        end
`endif

        // Randomized traffic with random consumer backpressure
        base = n_rsp;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    ra  = {$urandom, $urandom};
                    rb  = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) ra = '1;
                    rop = 8'($urandom_range(0, 5));
                    rd  = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(1, 5));
                    push(ra, rb, rop, 4'($urandom_range(0, 15)), rd, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                for (int c = 0; c < 4000 && n_rsp < base + 60; c++) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        rsp_ready = 1'b1;
        wait_rsp(base + 60, 600);
        check("scoreboard_empty", 136'(exp_q.size()), 136'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
